// File: rtl/seconds_display_if.sv
// Seconds-display bus: the seconds count from the counter plus the converted
// BCD value and the multiplexed 7-segment drive produced by the display block.
interface seconds_display_if #(
  parameter int WIDTH = 13
);
  logic [WIDTH-1:0] seconds;
  logic [6:0]       seg;
  logic             dp;
  logic [3:0]       an;
  logic [15:0]      bcd;
  logic             busy;

  modport master (output seconds, input seg, dp, an, bcd, busy);
  modport slave  (input seconds, output seg, dp, an, bcd, busy);
endinterface

// File: rtl/seconds_display.sv
// Binary seconds -> 4-digit BCD through a sequential double-dabble engine,
// scanned onto an active-low, time-multiplexed 7-segment display.
module seconds_display #(
  parameter int WIDTH         = 13,
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input logic              clk,
  input logic              rst,
  seconds_display_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [15:0] add3_nibbles(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] seconds_s;
  logic [WIDTH-1:0] last_sample_r, last_sample_s;
  logic [WIDTH-1:0] sample_r, sample_s;
  logic [15:0]      scratch_r, scratch_s, adj_s;
  logic [CW-1:0]    shift_cnt_r, shift_cnt_s;
  logic [15:0]      bcd_r, bcd_s;
  logic             busy_r, busy_s;

  logic [RW-1:0]    refresh_cnt_r, refresh_cnt_s;
  logic [1:0]       digit_idx_r, digit_idx_s;
  logic [3:0]       digit_s;
  logic             blank_s;
  logic [3:0]       an_r, an_s;
  logic [6:0]       seg_r, seg_s;
  logic             dp_r;

  assign seconds_s = bus.seconds;

  // Conversion FSM: next-state and datapath.
  always_comb begin
    state_s       = state_r;
    last_sample_s = last_sample_r;
    sample_s      = sample_r;
    scratch_s     = scratch_r;
    shift_cnt_s   = shift_cnt_r;
    bcd_s         = bcd_r;
    busy_s        = busy_r;
    adj_s         = add3_nibbles(scratch_r);
    case (state_r)
      IDLE: begin
        if (seconds_s != last_sample_r) begin
          last_sample_s = seconds_s;
          sample_s      = seconds_s;
          scratch_s     = 16'd0;
          shift_cnt_s   = CW'(WIDTH);
          busy_s        = 1'b1;
          state_s       = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        {scratch_s, sample_s} = {adj_s, sample_r} << 1'b1;
        shift_cnt_s = shift_cnt_r - CW'(1);
        if (shift_cnt_r == CW'(1)) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        bcd_s   = scratch_r;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // Conversion FSM: state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      last_sample_r <= '0;
      sample_r      <= '0;
      scratch_r     <= 16'd0;
      shift_cnt_r   <= '0;
      bcd_r         <= 16'd0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      last_sample_r <= last_sample_s;
      sample_r      <= sample_s;
      scratch_r     <= scratch_s;
      shift_cnt_r   <= shift_cnt_s;
      bcd_r         <= bcd_s;
      busy_r        <= busy_s;
    end
  end

  // Scan timing, digit select and leading-zero blanking.
  always_comb begin
    if (refresh_cnt_r == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt_s = '0;
      digit_idx_s   = digit_idx_r + 2'd1;
    end else begin
      refresh_cnt_s = refresh_cnt_r + RW'(1);
      digit_idx_s   = digit_idx_r;
    end
    case (digit_idx_s)
      2'd0:    begin digit_s = bcd_r[3:0];   blank_s = 1'b0; end
      2'd1:    begin digit_s = bcd_r[7:4];   blank_s = (bcd_r[15:4] == 12'd0); end
      2'd2:    begin digit_s = bcd_r[11:8];  blank_s = (bcd_r[15:8] == 8'd0); end
      2'd3:    begin digit_s = bcd_r[15:12]; blank_s = (bcd_r[15:12] == 4'd0); end
      default: begin digit_s = 4'd0;         blank_s = 1'b0; end
    endcase
    if (BLANK_LEADING && blank_s) begin
      an_s  = 4'b1111;
      seg_s = 7'h7F;
    end else begin
      an_s  = ~(4'b0001 << digit_idx_s);
      seg_s = seg_of(digit_s);
    end
  end

  // Scan registers; anode and cathode drive change together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt_r <= '0;
      digit_idx_r   <= 2'd0;
      an_r          <= 4'b1110;
      seg_r         <= 7'b1000000;
      dp_r          <= 1'b1;
    end else begin
      refresh_cnt_r <= refresh_cnt_s;
      digit_idx_r   <= digit_idx_s;
      an_r          <= an_s;
      seg_r         <= seg_s;
      dp_r          <= 1'b1;
    end
  end

  assign bus.bcd  = bcd_r;
  assign bus.busy = busy_r;
  assign bus.an   = an_r;
  assign bus.seg  = seg_r;
  assign bus.dp   = dp_r;
endmodule
